// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, rx_error_code values and
// 50 MHz timing constants used by the receiver and the command transmitter.
package ps2_pkg;

   localparam int unsigned SYS_CLK_HZ   = 50_000_000;
   localparam int unsigned CYCLES_2MS   = 100_000;
   localparam int unsigned CYCLES_2MS_W = 17;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_DATA_IN   = 3'd1,
      ST_PARITY_IN = 3'd2,
      ST_STOP_IN   = 3'd3,
      ST_DONE      = 3'd4
   } ps2_rx_state_e;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_PARITY  = 2'b01;
   localparam logic [1:0] ERR_FRAMING = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;

   // PS/2 uses odd parity over the data byte plus the parity bit.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction

endpackage

// File: rtl/ps2_data_in.sv
// PS/2 device-to-host byte receiver with inter-edge timeout.
// Build option: define PS2_PARITY_CHECK_EN to reject bytes with bad parity.
//
// state        | meaning
// ST_IDLE      | waiting for a start bit (negedge with data low) while enabled
// ST_DATA_IN   | shifting in 8 data bits, LSB first
// ST_PARITY_IN | waiting for the parity bit
// ST_STOP_IN   | waiting for the stop bit
// ST_DONE      | one cycle: publish byte or report framing/parity error
module ps2_data_in
   import ps2_pkg::*;
#(
   parameter int CLOCK_CYCLES_FOR_2MS   = CYCLES_2MS,
   parameter int NUMBER_OF_BITS_FOR_2MS = CYCLES_2MS_W
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_receiving_data,
   input  logic       ps2_clk_negedge,
   input  logic       ps2_data,
   output logic [7:0] received_data,
   output logic       received_data_en,
   output logic       rx_error,
   output logic [1:0] rx_error_code
);

`ifdef PS2_PARITY_CHECK_EN
   localparam bit PARITY_CHECK = 1'b1;
`else
   localparam bit PARITY_CHECK = 1'b0;
`endif

   localparam int TW = NUMBER_OF_BITS_FOR_2MS;
   localparam logic [TW-1:0] TMO_MAX = TW'(CLOCK_CYCLES_FOR_2MS);

   ps2_rx_state_e   state_q, state_d;
   logic [7:0]      shift_q, shift_d;
   logic [2:0]      bit_cnt_q, bit_cnt_d;
   logic            parity_q, parity_d;
   logic            stop_q, stop_d;
   logic [TW-1:0]   tmo_q, tmo_d;
   logic [7:0]      data_q, data_d;
   logic            data_en_q, data_en_d;
   logic            err_q, err_d;
   logic [1:0]      code_q, code_d;

   logic            receiving;
   logic [TW-1:0]   tmo_inc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         parity_q  <= 1'b0;
         stop_q    <= 1'b0;
         tmo_q     <= '0;
         data_q    <= '0;
         data_en_q <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         parity_q  <= parity_d;
         stop_q    <= stop_d;
         tmo_q     <= tmo_d;
         data_q    <= data_d;
         data_en_q <= data_en_d;
         err_q     <= err_d;
         code_q    <= code_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      stop_d    = stop_q;
      tmo_d     = tmo_q;
      data_d    = data_q;
      data_en_d = 1'b0;
      err_d     = 1'b0;
      code_d    = code_q;

      receiving = (state_q == ST_DATA_IN) || (state_q == ST_PARITY_IN) ||
                  (state_q == ST_STOP_IN);
      tmo_inc   = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + 1'b1;

      if (!start_receiving_data && state_q != ST_DONE) begin
         // Enable low silently abandons any partial frame.
         state_d   = ST_IDLE;
         tmo_d     = '0;
         bit_cnt_d = '0;
      end else if (receiving && !ps2_clk_negedge) begin
         tmo_d = tmo_inc;
         if (tmo_inc == TMO_MAX) begin
            state_d = ST_IDLE;
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
         end
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (ps2_clk_negedge && !ps2_data) begin
                  state_d   = ST_DATA_IN;
                  tmo_d     = '0;
                  bit_cnt_d = '0;
               end
            end
            ST_DATA_IN: begin
               shift_d   = {ps2_data, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               tmo_d     = '0;
               if (bit_cnt_q == 3'd7) state_d = ST_PARITY_IN;
            end
            ST_PARITY_IN: begin
               parity_d = ps2_data;
               tmo_d    = '0;
               state_d  = ST_STOP_IN;
            end
            ST_STOP_IN: begin
               stop_d  = ps2_data;
               tmo_d   = '0;
               state_d = ST_DONE;
            end
            ST_DONE: begin
               state_d = ST_IDLE;
               if (!stop_q) begin
                  err_d  = 1'b1;
                  code_d = ERR_FRAMING;
               end else if (PARITY_CHECK && !odd_parity_ok(shift_q, parity_q)) begin
                  err_d  = 1'b1;
                  code_d = ERR_PARITY;
               end else begin
                  data_d    = shift_q;
                  data_en_d = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign received_data    = data_q;
   assign received_data_en = data_en_q;
   assign rx_error         = err_q;
   assign rx_error_code    = code_q;

endmodule

// File: doc/ps2_data_in.md
PS2_DATA_IN -- requirements
Module: ps2_data_in

Interface
REQ-001 Parameter CLOCK_CYCLES_FOR_2MS, default 100000, inter-edge timeout in clk cycles (50 MHz).
REQ-002 Parameter NUMBER_OF_BITS_FOR_2MS, default 17, timeout counter width.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start_receiving_data  input  1  receive enable; low aborts or blocks reception.
REQ-006 ps2_clk_negedge  input  1  one-cycle pulse, synchronized PS/2 clock falling edge.
REQ-007 ps2_data  input  1  synchronized PS/2 data line level.
REQ-008 received_data  output  8  last good byte; holds until next good byte.
REQ-009 received_data_en  output  1  one-cycle pulse, received_data updated.
REQ-010 rx_error  output  1  one-cycle pulse, frame discarded.
REQ-011 rx_error_code  output  2  01 parity, 10 framing (stop=0), 11 timeout; holds last code.

Function
REQ-012 FSM states SHALL be IDLE, DATA_IN, PARITY_IN, STOP_IN, DONE.
REQ-013 IDLE: ps2_clk_negedge with ps2_data=0 and start_receiving_data=1 SHALL go to DATA_IN; otherwise stay.
REQ-014 DATA_IN: each negedge SHALL shift ps2_data in LSB first; after the 8th bit, go to PARITY_IN.
REQ-015 PARITY_IN: negedge SHALL capture the parity bit and go to STOP_IN.
REQ-016 STOP_IN: negedge SHALL sample the stop bit and go to DONE.
REQ-017 DONE lasts one cycle, then returns to IDLE.
REQ-018 DONE, frame valid: received_data_en pulses and received_data loads in the same cycle, two clk edges after the stop-bit negedge pulse.
REQ-019 Odd parity SHALL be required: XOR of 8 data bits and parity bit = 1.
REQ-020 Stop bit = 0 SHALL give rx_error, code 10. Framing takes priority over parity.
REQ-021 Timeout counter SHALL clear on entry to DATA_IN and on every negedge.
REQ-022 Timeout counter SHALL increment otherwise in DATA_IN/PARITY_IN/STOP_IN and saturate at CLOCK_CYCLES_FOR_2MS.
REQ-023 Counter at CLOCK_CYCLES_FOR_2MS SHALL give rx_error code 11 and go to IDLE.
REQ-024 Negedge in the same cycle as timeout SHALL win; timeout is ignored.
REQ-025 start_receiving_data low in any state other than DONE SHALL return to IDLE next cycle with no output or error pulse.
REQ-026 received_data_en and rx_error SHALL never assert in the same cycle.

Reset
REQ-027 Reset low SHALL force IDLE and clear the shift register, counters, received_data, rx_error_code, received_data_en and rx_error, independent of clk.
REQ-028 Reset mid-frame SHALL discard the partial frame; the first frame after release starts from IDLE.

Configuration
REQ-029 Macro PS2_PARITY_CHECK_EN defined: parity mismatch (stop=1) SHALL drop the byte and give rx_error code 01.
REQ-030 Macro PS2_PARITY_CHECK_EN undefined: parity SHALL be captured but ignored; code 01 never produced.

Structure
REQ-031 Shared package ps2_pkg SHALL hold state encodings, rx_error_code values and 50 MHz timing constants; ps2_data_in and the command transmitter use it.
REQ-032 Single module with one FSM; no sub-module.

Verification
REQ-033 Frame 0xAA (start 0, bits 0,1,0,1,0,1,0,1, parity 1, stop 1) -> received_data=0xAA, received_data_en one cycle, no rx_error.
REQ-034 0xAA with parity 0 -> macro defined: rx_error code 01, received_data unchanged; undefined: received_data=0xAA.
REQ-035 0xFA, parity 1, stop 0 -> rx_error code 10, no received_data_en.
REQ-036 Negedges stop after 4 data bits -> rx_error code 11 exactly 100000 cycles after the last negedge; FSM in IDLE.
REQ-037 start_receiving_data dropped after bit 3 -> IDLE next cycle, no pulses; a following 0x55 frame is received correctly.
REQ-038 Reset low mid-frame after bit 5 -> all outputs 0 immediately; the next full 0x12 frame (parity 1) is received correctly.
